// File: rtl/hamming_pkg.sv
// Shared types and geometry helpers for the SECDED Hamming receive path.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DECODE
  } rx_state_t;

  typedef enum logic [1:0] {
    CLEAN,
    CORR,
    DUAL
  } dec_result_t;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int hamming_par_bits(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // Codeword width including the overall parity bit at position 0.
  function automatic int hamming_cw_w(input int data_w);
    return data_w + hamming_par_bits(data_w) + 1;
  endfunction

endpackage

// File: rtl/secded_decode.sv
// Combinational SECDED decoder: syndrome, overall parity, single-bit
// correction and data extraction from the non-power-of-two positions.
module secded_decode
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CW_W   = hamming_cw_w(DATA_W)
) (
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output dec_result_t       res
);

  localparam int P = hamming_par_bits(DATA_W);

  logic [P-1:0]    syn;
  logic            par;
  logic [CW_W-1:0] corr;
  int              k;

  // Classify the codeword, flip the indicated bit, then gather data bits.
  always_comb begin
    syn  = '0;
    par  = ^cw;
    corr = cw;
    data = '0;
    res  = CLEAN;
    k    = 0;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) syn = syn ^ P'(i);
    end
    if (syn == '0 && !par) begin
      res = CLEAN;
    end else if (par && int'(syn) <= CW_W - 1) begin
      // syn == 0 here means only the overall parity bit was hit
      res = CORR;
    end else begin
      res = DUAL;
    end
    if (res == CORR) begin
      for (int i = 1; i < CW_W; i++) begin
        if (P'(i) == syn) corr[i] = ~corr[i];
      end
    end
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        data[k] = corr[i];
        k = k + 1;
      end
    end
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial SECDED receiver: synchroniser, mid-bit sampling FSM, decode and
// saturating error statistics.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | timing to mid start bit, rejects glitches
// DATA   | sampling CW_W codeword bits, LSB first
// STOP   | sampling stop bit, flags framing errors
// DECODE | one cycle, decoded result registered to outputs
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 27,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  input  logic              clr_cnt_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              err_corr_o,
  output logic              err_dual_o,
  output logic              frame_err_o,
  output logic [CNT_W-1:0]  corr_cnt_o,
  output logic [CNT_W-1:0]  dual_cnt_o
);

  localparam int CW_W = hamming_cw_w(DATA_W);
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(CW_W);

  rx_state_t       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW_W-1:0] shreg_q, shreg_d;
  logic            sync1_q, rx_s, rx_prev_q;
  logic            tick, frame_err_d, do_decode;
  logic [DATA_W-1:0] dec_data;
  dec_result_t     dec_res;

  secded_decode #(.DATA_W(DATA_W)) u_dec (
    .cw   (shreg_q),
    .data (dec_data),
    .res  (dec_res)
  );

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      rx_s      <= sync1_q;
      rx_prev_q <= rx_s;
    end
  end

  // State, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  assign tick = (timer_q == '0);

  // Next-state logic; the timer is a down-counter reloaded at each sample.
  always_comb begin
    state_d     = state_q;
    timer_d     = tick ? timer_q : timer_q - 1'b1;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    do_decode   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          timer_d = TW'(CLKS_PER_BIT / 2 - 1);
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            timer_d = TW'(CLKS_PER_BIT - 1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d[idx_q] = rx_s;
          timer_d        = TW'(CLKS_PER_BIT - 1);
          if (idx_q == IW'(CW_W - 1)) state_d = STOP;
          else idx_d = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            state_d = DECODE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      DECODE: begin
        do_decode = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and saturating counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      err_corr_o  <= 1'b0;
      err_dual_o  <= 1'b0;
      frame_err_o <= 1'b0;
      corr_cnt_o  <= '0;
      dual_cnt_o  <= '0;
    end else begin
      valid_o     <= 1'b0;
      err_corr_o  <= 1'b0;
      err_dual_o  <= 1'b0;
      frame_err_o <= frame_err_d;
      if (do_decode && dec_res != DUAL) begin
        data_o     <= dec_data;
        valid_o    <= 1'b1;
        err_corr_o <= (dec_res == CORR);
      end
      if (do_decode && dec_res == DUAL) err_dual_o <= 1'b1;
      if (clr_cnt_i) corr_cnt_o <= '0;
      else if (do_decode && dec_res == CORR && corr_cnt_o != '1)
        corr_cnt_o <= corr_cnt_o + 1'b1;
      if (clr_cnt_i) dual_cnt_o <= '0;
      else if (do_decode && dec_res == DUAL && dual_cnt_o != '1)
        dual_cnt_o <= dual_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Scoreboard bench for hamming_serial_rx with DATA_W=4, CLKS_PER_BIT=4, CNT_W=2.
module tb_hamming_serial_rx;

  localparam int DATA_W = 4;
  localparam int CLKS   = 4;
  localparam int CNT_W  = 2;
  localparam int CW_W   = 8;

  localparam int K_CLEAN = 0;
  localparam int K_CORR  = 1;
  localparam int K_DUAL  = 2;
  localparam int K_FRAME = 3;

  typedef struct {
    int kind;
    int data;
    int corr_cnt;
    int dual_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_i = 1'b1;
  logic clr_cnt_i = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic valid_o, err_corr_o, err_dual_o, frame_err_o;
  logic [CNT_W-1:0] corr_cnt_o, dual_cnt_o;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int pulses_seen = 0;
  int m_corr = 0;
  int m_dual = 0;

  always #5 clk = ~clk;

  hamming_serial_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CLKS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .clr_cnt_i   (clr_cnt_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .err_corr_o  (err_corr_o),
    .err_dual_o  (err_dual_o),
    .frame_err_o (frame_err_o),
    .corr_cnt_o  (corr_cnt_o),
    .dual_cnt_o  (dual_cnt_o)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: any output pulse pops one expected entry and is compared.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (valid_o || err_corr_o || err_dual_o || frame_err_o)) begin
      pulses_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("valid_o",     int'(valid_o),     int'(e.kind == K_CLEAN || e.kind == K_CORR));
        check("err_corr_o",  int'(err_corr_o),  int'(e.kind == K_CORR));
        check("err_dual_o",  int'(err_dual_o),  int'(e.kind == K_DUAL));
        check("frame_err_o", int'(frame_err_o), int'(e.kind == K_FRAME));
        check("data_o",      int'(data_o),      e.data);
        check("corr_cnt_o",  int'(corr_cnt_o),  e.corr_cnt);
        check("dual_cnt_o",  int'(dual_cnt_o),  e.dual_cnt);
      end
    end
  end

  task automatic push_exp(input int kind, input int data);
    exp_t e;
    if (kind == K_CORR && m_corr < 3) m_corr++;
    if (kind == K_DUAL && m_dual < 3) m_dual++;
    e.kind = kind;
    e.data = data;
    e.corr_cnt = m_corr;
    e.dual_cnt = m_dual;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CLKS) @(negedge clk);
  endtask

  // Full frame followed by a one-bit idle gap.
  task automatic send_frame(input logic [CW_W-1:0] cw, input logic stop,
                            input int kind, input int data);
    push_exp(kind, data);
    send_bit(1'b0);
    for (int i = 0; i < CW_W; i++) send_bit(cw[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    check("reset_data_o", int'(data_o), 0);
    check("reset_valid_o", int'(valid_o), 0);
    check("reset_corr_cnt", int'(corr_cnt_o), 0);
    check("reset_dual_cnt", int'(dual_cnt_o), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, K_CLEAN, 4'hA);  // clean
    send_frame(8'h85, 1'b1, K_CORR,  4'hA);  // position 5 flipped
    send_frame(8'hA4, 1'b1, K_CORR,  4'hA);  // overall parity bit flipped
    send_frame(8'h3C, 1'b1, K_CLEAN, 4'h3);  // clean data 0x3
    send_frame(8'hC5, 1'b1, K_DUAL,  4'h3);  // bits 5,6 flipped, data held
    send_frame(8'hA5, 1'b0, K_FRAME, 4'h3);  // bad stop bit, data held
    drain("drain_basic");

    // One-cycle low glitch on an idle line must produce nothing.
    p0 = pulses_seen;
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_pulse", pulses_seen - p0, 0);
    send_frame(8'hA5, 1'b1, K_CLEAN, 4'hA);
    drain("drain_after_glitch");

    clr_cnt_i = 1'b1;
    @(negedge clk);
    clr_cnt_i = 1'b0;
    m_corr = 0;
    m_dual = 0;
    check("clr_corr_cnt", int'(corr_cnt_o), 0);
    check("clr_dual_cnt", int'(dual_cnt_o), 0);

    // Five corrected frames back to back saturate a 2-bit counter at 3.
    for (int i = 0; i < 5; i++) send_frame(8'h85, 1'b1, K_CORR, 4'hA);
    drain("drain_sat");
    check("sat_corr_cnt", int'(corr_cnt_o), 3);
    clr_cnt_i = 1'b1;
    @(negedge clk);
    clr_cnt_i = 1'b0;
    m_corr = 0;
    check("sat_clr_corr_cnt", int'(corr_cnt_o), 0);

    // Bring the outputs to nonzero, then reset in the middle of DATA.
    send_frame(8'h85, 1'b1, K_CORR, 4'hA);
    drain("drain_pre_reset");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_data_o", int'(data_o), 0);
    check("rst_valid_o", int'(valid_o), 0);
    check("rst_err_corr_o", int'(err_corr_o), 0);
    check("rst_err_dual_o", int'(err_dual_o), 0);
    check("rst_frame_err_o", int'(frame_err_o), 0);
    check("rst_corr_cnt", int'(corr_cnt_o), 0);
    check("rst_dual_cnt", int'(dual_cnt_o), 0);
    rx_i = 1'b1;
    m_corr = 0;
    m_dual = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses_seen;
    repeat (60) @(negedge clk);
    check("post_reset_no_pulse", pulses_seen - p0, 0);
    send_frame(8'h3C, 1'b1, K_CLEAN, 4'h3);
    drain("drain_post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
